// File: rtl/dft_stream.sv
// Streaming N-point DFT: loads a frame of real samples, computes each bin with LANES
// parallel MACs against an elaborated twiddle ROM, emits bins with backpressure.
// Optional inverse transform when DFT_INVERSE_EN is defined (adds port `inverse`).
module dft_stream #(
  parameter int N        = 64,
  parameter int LANES    = 8,
  parameter int DW       = 16,
  parameter int TW       = 16,
  parameter int OUT_BINS = 64,
  localparam int OW      = DW + $clog2(N)
) (
  input  logic                    clk,
  input  logic                    sreset,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DW-1:0]     in_data,
`ifdef DFT_INVERSE_EN
  input  logic                    inverse,
`endif
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(N)-1:0]    out_bin,
  output logic signed [OW-1:0]    out_real,
  output logic signed [OW-1:0]    out_imag,
  output logic                    done
);

  localparam int LOG   = $clog2(N);
  localparam int BEATS = N / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PW    = DW + TW;
  localparam int ACW   = PW + LOG;
  localparam logic [BW-1:0]  BLAST = BW'(BEATS - 1);
  localparam logic [LOG-1:0] KLAST = LOG'(OUT_BINS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, EMIT} state_t;
  state_t state, state_n;

  logic [BW-1:0]          beat, cyc;
  logic [LOG-1:0]         k;
  logic signed [ACW-1:0]  acc_re, acc_im, acc_re_n, acc_im_n, sum_re, sum_im;
  logic signed [OW-1:0]   res_re, res_im;
  logic signed [DW-1:0]   x [N];
  logic signed [TW-1:0]   cos_t [N];
  logic signed [TW-1:0]   sin_t [N];
  logic                   accept, hs;

  // Twiddles rounded to nearest with 1.0 = 2**(TW-2)
  function automatic int twiddle(input int m, input bit is_sin);
    real a, v;
    a = 2.0 * 3.14159265358979323846 * real'(m) / real'(N);
    v = (is_sin ? $sin(a) : $cos(a)) * real'(2 ** (TW - 2));
    return $rtoi((v >= 0.0) ? v + 0.5 : v - 0.5);
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_rom
    localparam int CV = twiddle(i, 1'b0);
    localparam int SV = twiddle(i, 1'b1);
    assign cos_t[i] = TW'(CV);
    assign sin_t[i] = TW'(SV);
  end

`ifdef DFT_INVERSE_EN
  logic inv;
  always_ff @(posedge clk or posedge sreset) begin
    if (sreset)                           inv <= 1'b0;
    else if (accept && state == IDLE)     inv <= inverse;
  end
`endif

  always_ff @(posedge clk or posedge sreset) begin
    if (sreset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = (BEATS == 1) ? COMPUTE : LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid && beat == BLAST) state_n = COMPUTE;
      end
      COMPUTE: if (cyc == BLAST) state_n = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready) state_n = (k == KLAST) ? IDLE : COMPUTE;
      end
      default: state_n = IDLE;
    endcase
    if (clear || sreset) begin
      state_n   = IDLE;
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end
  end

  assign accept  = in_valid && in_ready;
  assign hs      = out_valid && out_ready;
  assign out_bin = k;

  // Lane 0 sits in the MSBs and is the earliest sample of the beat
  always_ff @(posedge clk) begin
    if (accept)
      for (int unsigned l = 0; l < LANES; l++)
        x[int'(beat) * LANES + int'(l)] <= in_data[(LANES - 1 - l) * DW +: DW];
  end

  // Twiddle index k*n wraps mod N by truncation to LOG bits
  always_comb begin
    logic [LOG-1:0] n, m;
    logic signed [ACW-1:0] base_re, base_im;
    n = '0;
    m = '0;
    sum_re = '0;
    sum_im = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      n = LOG'(int'(cyc) * LANES + int'(l));
      m = k * n;
      sum_re = sum_re + ACW'(PW'(x[n]) * PW'(cos_t[m]));
      sum_im = sum_im + ACW'(PW'(x[n]) * PW'(sin_t[m]));
    end
    base_re  = (cyc == '0) ? '0 : acc_re;
    base_im  = (cyc == '0) ? '0 : acc_im;
    acc_re_n = base_re + sum_re;
`ifdef DFT_INVERSE_EN
    acc_im_n = inv ? base_im + sum_im : base_im - sum_im;
    res_re   = inv ? OW'(acc_re_n >>> (TW - 2 + LOG)) : OW'(acc_re_n >>> (TW - 2));
    res_im   = inv ? OW'(acc_im_n >>> (TW - 2 + LOG)) : OW'(acc_im_n >>> (TW - 2));
`else
    acc_im_n = base_im - sum_im;
    res_re   = OW'(acc_re_n >>> (TW - 2));
    res_im   = OW'(acc_im_n >>> (TW - 2));
`endif
  end

  always_ff @(posedge clk or posedge sreset) begin
    if (sreset) begin
      beat     <= '0;
      cyc      <= '0;
      k        <= '0;
      acc_re   <= '0;
      acc_im   <= '0;
      out_real <= '0;
      out_imag <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        beat   <= '0;
        cyc    <= '0;
        k      <= '0;
        acc_re <= '0;
        acc_im <= '0;
      end else begin
        if (accept) beat <= (beat == BLAST) ? '0 : beat + 1'b1;
        if (state == COMPUTE) begin
          acc_re <= acc_re_n;
          acc_im <= acc_im_n;
          cyc    <= (cyc == BLAST) ? '0 : cyc + 1'b1;
          if (cyc == BLAST) begin
            out_real <= res_re;
            out_imag <= res_im;
          end
        end
        if (hs) begin
          if (k == KLAST) begin
            k    <= '0;
            done <= 1'b1;
          end else begin
            k <= k + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dft_stream.sv
// Self-checking bench for dft_stream (forward build): random and structured frames
// compared bin-by-bin against a direct DFT reference computed in the bench.
module tb_dft_stream;
  localparam int N = 64, LANES = 8, DW = 16, TW = 16, OUT_BINS = 64;
  localparam int OW = DW + $clog2(N);
  localparam int BEATS = N / LANES;

  logic clk = 1'b0;
  logic sreset, clear, in_valid, in_ready, out_valid, out_ready, done;
  logic [LANES*DW-1:0] in_data;
  logic [$clog2(N)-1:0] out_bin;
  logic signed [OW-1:0] out_real, out_imag;

  int passed = 0, total = 0;
  int frame [N];
  logic signed [OW-1:0] exp_re [N];
  logic signed [OW-1:0] exp_im [N];
  longint cycle_cnt = 0;

  dft_stream #(.N(N), .LANES(LANES), .DW(DW), .TW(TW), .OUT_BINS(OUT_BINS)) dut (
    .clk(clk), .sreset(sreset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
    .out_real(out_real), .out_imag(out_imag), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt++;

  function automatic int tw(input int m, input bit s);
    real a, v;
    a = 2.0 * 3.14159265358979323846 * real'(m) / real'(N);
    v = (s ? $sin(a) : $cos(a)) * 16384.0;
    return $rtoi((v >= 0.0) ? v + 0.5 : v - 0.5);
  endfunction

  // Direct DFT: X[k] = sum x[n] * (cos - j sin)(2 pi k n / N), scaled down by 2**14 with floor
  task automatic build_model();
    for (int k = 0; k < N; k++) begin
      longint re = 0, im = 0;
      for (int n = 0; n < N; n++) begin
        re += longint'(frame[n]) * longint'(tw((k * n) % N, 1'b0));
        im -= longint'(frame[n]) * longint'(tw((k * n) % N, 1'b1));
      end
      exp_re[k] = OW'(re >>> 14);
      exp_im[k] = OW'(im >>> 14);
    end
  endtask

  task automatic random_frame();
    logic signed [15:0] s;
    for (int n = 0; n < N; n++) begin
      s = 16'($urandom);
      frame[n] = s;
    end
  endtask

  task automatic send_frame(input int nbeats, output longint t0);
    int guard;
    t0 = -1;
    for (int b = 0; b < nbeats; b++) begin
      for (int l = 0; l < LANES; l++) in_data[(LANES - 1 - l) * DW +: DW] = DW'(frame[b * LANES + l]);
      in_valid = 1'b1;
      guard = 0;
      while (!in_ready && guard < 2000) begin
        @(posedge clk); #1; guard++;
      end
      if (!in_ready) begin
        total++;
        $display("FAIL send_beat%0d: in_ready=%0b after %0d cycles, required 1", b, in_ready, guard);
        in_valid = 1'b0;
        return;
      end
      if (b == 0) t0 = cycle_cnt;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int rdy_pct, input int nbins, output int ndone, output longint tdone);
    int k = 0, guard = 0;
    bit stalled = 0;
    logic [$clog2(N)-1:0] hb;
    logic signed [OW-1:0] hr, hi;
    ndone = 0; tdone = -1;
    hb = '0; hr = '0; hi = '0;
    while (k < nbins && guard < 20000) begin
      out_ready = ($urandom_range(0, 99) < rdy_pct);
      if (done) begin ndone++; tdone = cycle_cnt; end
      if (out_valid) begin
        if (stalled) begin
          total++;
          if ({out_bin, out_real, out_imag} !== {hb, hr, hi})
            $display("FAIL stall_hold: bin=%0d re=%0d im=%0d, held bin=%0d re=%0d im=%0d",
                     out_bin, out_real, out_imag, hb, hr, hi);
          else passed++;
        end
        if (out_ready) begin
          total++;
          if (out_bin !== 6'(k) || out_real !== exp_re[k] || out_imag !== exp_im[k])
            $display("FAIL bin%0d: got bin=%0d re=%0d im=%0d, expected bin=%0d re=%0d im=%0d",
                     k, out_bin, out_real, out_imag, k, exp_re[k], exp_im[k]);
          else passed++;
          k++; stalled = 0;
        end else begin
          stalled = 1; hb = out_bin; hr = out_real; hi = out_imag;
        end
      end
      @(posedge clk); #1; guard++;
    end
    if (k < nbins) begin
      total++;
      $display("FAIL collect_timeout: got %0d bins, required %0d", k, nbins);
    end
    if (nbins == N) begin
      for (int i = 0; i < 4; i++) begin
        if (done) begin ndone++; tdone = cycle_cnt; end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic full_frame(input string name, input int rdy_pct, input bit check_lat);
    longint t0, td;
    int nd;
    build_model();
    send_frame(BEATS, t0);
    collect(rdy_pct, N, nd, td);
    total++;
    if (nd !== 1) $display("FAIL %s_done_count: got %0d pulses, required 1", name, nd);
    else passed++;
    if (check_lat) begin
      total++;
      if (td - t0 !== 584) $display("FAIL %s_latency: got %0d cycles, required 584", name, td - t0);
      else passed++;
    end
  endtask

  task automatic test_reset();
    sreset = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid, done} !== 3'b000)
      $display("FAIL reset_flags: in_ready=%0b out_valid=%0b done=%0b, required 0 0 0", in_ready, out_valid, done);
    else passed++;
    total++;
    if (out_bin !== 6'd0 || out_real !== '0 || out_imag !== '0)
      $display("FAIL reset_data: bin=%0d re=%0d im=%0d, required 0 0 0", out_bin, out_real, out_imag);
    else passed++;
    sreset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_impulse();
    for (int n = 0; n < N; n++) frame[n] = 0;
    frame[0] = 256;
    full_frame("impulse", 100, 1'b1);
  endtask

  task automatic test_dc_and_sine();
    for (int n = 0; n < N; n++) frame[n] = 256;
    full_frame("dc", 100, 1'b0);
    for (int n = 0; n < N; n++) begin
      real v;
      v = 256.0 * $sin(2.0 * 3.14159265358979323846 * 4.0 * real'(n) / 64.0);
      frame[n] = $rtoi((v >= 0.0) ? v + 0.5 : v - 0.5);
    end
    full_frame("sine", 100, 1'b0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 2; f++) begin
      random_frame();
      full_frame("random", 100, 1'b0);
    end
  endtask

  task automatic test_backpressure();
    random_frame();
    full_frame("backpressure", 40, 1'b0);
  endtask

  task automatic test_clear();
    longint t0;
    int seen = 0;
    random_frame();
    send_frame(3, t0);
    in_valid = 1'b1; clear = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b0) $display("FAIL clear_in_ready: got %0b, required 0", in_ready);
    else passed++;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid || done) seen++;
      @(posedge clk); #1;
    end
    total++;
    if (seen !== 0) $display("FAIL clear_no_output: got %0d active cycles, required 0", seen);
    else passed++;
    for (int n = 0; n < N; n++) frame[n] = 0;
    frame[0] = 256;
    full_frame("after_clear", 100, 1'b1);
  endtask

  task automatic test_reset_mid();
    longint t0, td;
    int nd;
    random_frame();
    build_model();
    send_frame(BEATS, t0);
    collect(100, 10, nd, td);
    repeat (3) @(posedge clk);
    #1;
    sreset = 1'b1;
    #1;
    total++;
    if ({in_ready, out_valid, done} !== 3'b000 || out_bin !== 6'd0 || out_real !== '0 || out_imag !== '0)
      $display("FAIL reset_mid: in_ready=%0b out_valid=%0b done=%0b bin=%0d re=%0d im=%0d, required all 0",
               in_ready, out_valid, done, out_bin, out_real, out_imag);
    else passed++;
    @(posedge clk); #1;
    sreset = 1'b0;
    @(posedge clk); #1;
    random_frame();
    full_frame("post_reset", 100, 1'b1);
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc_and_sine();
    test_random();
    test_backpressure();
    test_clear();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1);
  end

endmodule
